// File: rtl/ysyx_24110015_alu_arbiter.sv
// Purpose     : shares one combinational ALU between two requesters, one operation at a time, round-robin on ties.
// Latency     : accept at edge N, operands on the ALU during cycle N+1, result valid from cycle N+2 (min 3-cycle accept interval).
// Backpressure: the result is held until the owner raises resp_ready; no new request is accepted until then.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   req_valid/req_ready[1:0]   per-requester request handshake
//   req_data1/2, req_op [1:0]  per-requester operands and ALU op
//   resp_valid/resp_ready[1:0] per-requester response handshake
//   resp_data                  shared result, qualified by resp_valid[i]
//   alu_data1/2, alu_op        to the shared ALU
//   alu_out                    from the shared ALU (combinational)
//   busy                       high whenever an operation is in flight
module ysyx_24110015_alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][DATA_WIDTH-1:0] req_data1,
    input  logic [1:0][DATA_WIDTH-1:0] req_data2,
    input  logic [1:0][3:0]            req_op,
    output logic [1:0]                 resp_valid,
    input  logic [1:0]                 resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_data,
    output logic [DATA_WIDTH-1:0]      alu_data1,
    output logic [DATA_WIDTH-1:0]      alu_data2,
    output logic [3:0]                 alu_op,
    input  logic [DATA_WIDTH-1:0]      alu_out,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;
    logic                   owner_q, owner_d;
    logic [3:0]             op_q, op_d;
    logic [DATA_WIDTH-1:0]  a_q, a_d;
    logic [DATA_WIDTH-1:0]  b_q, b_d;
    logic [DATA_WIDTH-1:0]  res_q, res_d;

    logic                   gnt;
    logic                   accept;
    logic                   resp_done;

    // Grant: prio breaks a tie, otherwise whichever requester is valid.
    // With nothing valid gnt is don't-care; accept is gated by req_valid.
    always_comb begin
        gnt       = (req_valid == 2'b11) ? prio_q : req_valid[1];
        accept    = (state_q == IDLE) && req_valid[gnt];
        resp_done = (state_q == RESP) && resp_ready[owner_q];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (resp_done) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        if (state_q == IDLE && req_valid != 2'b00) begin
            req_ready[gnt] = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
        busy      = (state_q != IDLE);
        resp_data = res_q;
        // The ALU always sees the registered operands; only the EXEC cycle matters.
        alu_data1 = a_q;
        alu_data2 = b_q;
        alu_op    = op_q;
    end

    // Datapath next values
    always_comb begin
        prio_d  = prio_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (accept) begin
            owner_d = gnt;
            op_d    = req_op[gnt];
            a_d     = req_data1[gnt];
            b_d     = req_data2[gnt];
        end
        if (state_q == EXEC) begin
            res_d = alu_out;
        end
        // The requester just served loses the next tie.
        if (resp_done) begin
            prio_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            prio_q  <= prio_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_alu_arbiter.sv
module tb_ysyx_24110015_alu_arbiter;

    localparam int DW = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_SRA = 4'd3;
    localparam logic [3:0] OP_RSV = 4'b1111;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][DW-1:0]   req_data1;
    logic [1:0][DW-1:0]   req_data2;
    logic [1:0][3:0]      req_op;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [DW-1:0]        resp_data;
    logic [DW-1:0]        alu_data1;
    logic [DW-1:0]        alu_data2;
    logic [3:0]           alu_op;
    logic [DW-1:0]        alu_out;
    logic                 busy;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp;
    int       n_err;

    ysyx_24110015_alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .busy       (busy)
    );

    // Behavioural stand-in for the shared ALU; unmapped ops return 0.
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_data1 + alu_data2;
            OP_SUB:  alu_out = alu_data1 - alu_data2;
            OP_SLL:  alu_out = alu_data1 << alu_data2[4:0];
            OP_SRA:  alu_out = $signed(alu_data1) >>> alu_data2[4:0];
            default: alu_out = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [DW-1:0] data);
        sb_item_t it;
        it.owner = owner;
        it.data  = data;
        sb_q.push_back(it);
    endtask

    // Present a request on requester r, wait for its grant, drop valid after the accept edge.
    task automatic send(input int r, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp, input bit expect_resp);
        int n;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_data1[r] = a;
        req_data2[r] = b;
        n = 0;
        #1;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            check_eq("grant_timeout", 0, 1);
        end else if (expect_resp) begin
            push_exp(r[0], exp);
        end
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (busy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int r);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!resp_valid[r] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check_eq("resp_timeout", 0, 1);
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        #2;
        if (rst_n && resp_valid != 2'b00) begin
            check_eq("resp_onehot", {63'd0, $onehot(resp_valid)}, 64'd1);
            for (int i = 0; i < 2; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("unexpected_resp", 64'(i), 64'hFF);
                    end else begin
                        sb_item_t it;
                        it = sb_q.pop_front();
                        check_eq("resp_owner", 64'(i), {63'd0, it.owner});
                        check_eq("resp_data", {32'd0, resp_data}, {32'd0, it.data});
                    end
                end
            end
        end
    end

    initial begin
        int n;
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data1  = '0;
        req_data2  = '0;
        req_op     = '0;
        resp_ready = '0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            req_valid  = 2'($urandom);
            req_op     = 8'($urandom);
            req_data1  = {$urandom, $urandom};
            req_data2  = {$urandom, $urandom};
            resp_ready = 2'($urandom);
            #1;
            check_eq("rst_resp_valid", resp_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_alu_op", alu_op, 0);
            check_eq("rst_resp_data", resp_data, 0);
        end
        @(negedge clk);
        req_valid    = 2'b10;
        req_op[1]    = OP_ADD;
        req_data1[1] = 32'd100;
        req_data2[1] = 32'd23;
        resp_ready   = 2'b11;
        rst_n        = 1'b1;
        #1;
        check_eq("rst_release_ready", req_ready, 2'b10);
        push_exp(1'b1, 32'd123);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Single ADD on requester 0 with exact cycle timing
        send(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b1);
        @(negedge clk);
        #1;
        check_eq("exec_busy", busy, 1);
        check_eq("exec_a", alu_data1, 5);
        check_eq("exec_b", alu_data2, 7);
        check_eq("exec_op", alu_op, OP_ADD);
        check_eq("exec_ready", req_ready, 0);
        @(negedge clk);
        #1;
        check_eq("add_resp_valid", resp_valid, 2'b01);
        check_eq("add_resp_data", resp_data, 12);
        @(negedge clk);
        #1;
        check_eq("add_busy_low", busy, 0);

        // Reserved op passes through and returns 0; completes with owner 1 so prio=0
        send(1, OP_RSV, 32'd3, 32'd3, 32'd0, 1'b1);
        @(negedge clk);
        #1;
        check_eq("rsv_op", alu_op, OP_RSV);
        wait_idle();

        // Tie: both requesters held valid continuously
        @(negedge clk);
        req_valid    = 2'b11;
        req_op[0]    = OP_SUB;
        req_data1[0] = 32'd10;
        req_data2[0] = 32'd3;
        req_op[1]    = OP_SLL;
        req_data1[1] = 32'd1;
        req_data2[1] = 32'd4;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 20) begin
                check_eq("tie_timeout", 0, 1);
            end else begin
                check_eq("tie_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
                push_exp(req_ready[1], req_ready[1] ? 32'd16 : 32'd7);
            end
            if (k == 3) begin
                @(posedge clk);
                #1;
                req_valid = 2'b00;
            end else begin
                @(negedge clk);
            end
        end
        wait_idle();

        // Response backpressure on requester 1, requester 0 waiting meanwhile
        resp_ready = 2'b01;
        send(1, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
        wait_resp(1);
        req_valid[0] = 1'b1;
        req_op[0]    = OP_ADD;
        req_data1[0] = 32'd1;
        req_data2[0] = 32'd2;
        repeat (5) begin
            check_eq("bp_data", resp_data, 32'hF800_0000);
            check_eq("bp_valid", resp_valid, 2'b10);
            check_eq("bp_ready", req_ready, 2'b00);
            @(negedge clk);
            #1;
        end
        resp_ready = 2'b11;
        send(0, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b1);
        wait_idle();

        // Reset during EXEC (prio is 1 beforehand)
        send(0, OP_ADD, 32'd9, 32'd9, 32'd18, 1'b0);
        @(negedge clk);
        #1;
        check_eq("pre_rst_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_exec_busy", busy, 0);
        check_eq("rst_exec_valid", resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_exec_no_resp", resp_valid, 0);
        end
        req_valid    = 2'b11;
        req_op[0]    = OP_ADD;
        req_data1[0] = 32'd20;
        req_data2[0] = 32'd22;
        req_op[1]    = OP_SUB;
        req_data1[1] = 32'd50;
        req_data2[1] = 32'd8;
        #1;
        check_eq("rst_exec_prio", req_ready, 2'b01);
        push_exp(1'b0, 32'd42);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Reset during RESP (prio is 1 beforehand)
        resp_ready = 2'b01;
        send(1, OP_SUB, 32'd50, 32'd8, 32'd42, 1'b0);
        wait_resp(1);
        check_eq("pre_rst_resp_valid", resp_valid, 2'b10);
        rst_n = 1'b0;
        #1;
        check_eq("rst_resp_busy", busy, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 2'b11;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_resp_no_resp", resp_valid, 0);
        end
        req_valid = 2'b11;
        #1;
        check_eq("rst_resp_prio", req_ready, 2'b01);
        push_exp(1'b0, 32'd42);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_idle();

        // Drain scoreboard
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("sb_empty", 64'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_alu_arbiter.md
# ysyx_24110015_alu_arbiter

Shares one combinational ALU between two requesters (requester 0: EXU, requester 1: LSU/address or CSR helper path). Accepts one operation at a time through a valid/ready request handshake, grants requesters round-robin, drives the ALU from registered operands, registers the result, and returns it on a valid/ready response handshake. The block sits between the requesting units and the single ALU instance.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid[i] (i=0,1)  in  1  requester i presents an operation.
- req_ready[i]  out  1  arbiter accepts requester i this cycle.
- req_data1[i], req_data2[i]  in  DATA_WIDTH  operands.
- req_op[i]  in  4  ALU operation, ALU_* encoding from macros.v.
- resp_valid[i]  out  1  result for requester i is available.
- resp_ready[i]  in  1  requester i consumes the result.
- resp_data  out  DATA_WIDTH  result, shared by both requesters; qualified by resp_valid[i].
- alu_data1, alu_data2  out  DATA_WIDTH  to ALU data1/data2.
- alu_op  out  4  to ALU ALUop.
- alu_out  in  DATA_WIDTH  from ALU ALUout (combinational).
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: the arbiter grants one requester with req_valid high. With both valid, it grants the requester pointed to by prio (0 or 1). With one valid, it grants that requester regardless of prio. req_ready[g] is high only for the granted requester, combinationally in IDLE. If req_valid[g] && req_ready[g], the arbiter latches op_r, a_r, b_r and owner=g, then goes to EXEC. With no request it stays in IDLE.
- EXEC (exactly 1 cycle): alu_data1=a_r, alu_data2=b_r, alu_op=op_r. At the edge the arbiter captures res_r=alu_out and goes to RESP.
- RESP: resp_valid[owner]=1, resp_data=res_r. It holds these until resp_ready[owner]=1. At that handshake edge it goes to IDLE and sets prio = ~owner, so the other requester wins the next tie.
- Outside EXEC, the alu_* outputs keep the last registered operands. Consumers ignore them.
- req_ready is 0 in EXEC and RESP, so no new request is accepted until the response completes. There is no back-to-back overlap.
- The arbiter passes ALU ops 4'b1110 and 4'b1111 through unchanged. The result is the ALU's output, which is 0 for these ops. No error is flagged.
- Inputs from the non-owner are ignored outside IDLE. Its req_valid may stay high; it is granted on the next IDLE cycle.
- Width rules: the block performs no arithmetic on data. Operands and result are passed bit-exact at DATA_WIDTH.

## Timing
- Reset (asynchronous, rst_n=0):
  - State, control: state=IDLE, prio=0, owner=0, busy=0.
  - Registers: op_r=0, a_r=0, b_r=0, res_r=0.
  - Outputs: resp_valid=0, resp_data=0, alu_*=0.
  - req_ready follows IDLE arbitration as soon as reset releases.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. No response is ever issued for it, and the requester must reissue.
- Latency: request accepted at edge N (cycle 0). EXEC occurs in cycle 1. resp_valid is high from cycle 2.
  - Minimum accept-to-accept interval is 3 cycles, when resp_ready is high on the first RESP cycle.
- The result stays stable while resp_valid is high and resp_ready is low, for any number of cycles.
- req_ready depends combinationally on req_valid and state only. It does not depend on resp_ready.

## Test plan
- Reset value check: hold rst_n=0 with random inputs. Require resp_valid=0, busy=0, alu_op=0, resp_data=0. Release reset with req_valid[1]=1 only; req_ready[1] must be 1 in that cycle.
- Single ADD on requester 0: send op=ALU_ADD, 5 and 7 with resp_ready[0]=1. Require EXEC one cycle later with alu_data1=5, alu_data2=7; resp_valid[0]=1, resp_data=12 two cycles after accept; busy low the next cycle.
- Tie with round-robin: hold req_valid on both requesters continuously, requester 0 SUB 10,3 and requester 1 SLL 1,4. Require grants in order 0,1,0,1 with results 7 and 16 alternating, and resp_valid never high on both requesters at once.
- Response backpressure: requester 1 sends ALU_SRA 0x80000000,4 with resp_ready[1]=0 for 5 cycles. Require resp_data=0xF8000000 held stable and req_ready=0 on both ports throughout. Completion occurs on the cycle resp_ready[1]=1.
- Reserved op: send op=4'b1111, 3,3. Require a normal handshake and resp_data=0.
- Reset mid-operation: assert rst_n=0 during EXEC and also, in a second run, during RESP. Require immediate return to IDLE with no resp_valid pulse and prio=0 after release.
